// File: rtl/pcs_receive_if.sv
// Code-group input and GMII-side receive outputs of the PCS receive block.
// The synchronization stage drives the master side; pcs_receive owns the slave side.
interface pcs_receive_if;
    logic        sync_status;
    logic        rx_even;
    logic [9:0]  sudi;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic        receiving;
    logic        frame_done;
    logic [11:0] frame_len;

    modport master (
        output sync_status, rx_even, sudi,
        input  rxd, rx_dv, rx_er, receiving, frame_done, frame_len
    );

    modport slave (
        input  sync_status, rx_even, sudi,
        output rxd, rx_dv, rx_er, receiving, frame_done, frame_len
    );
endinterface

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: decodes a reduced 8b/10b code-group set, tracks
// idle/frame delimiters and produces registered GMII rxd/rx_dv/rx_er plus frame length.
module pcs_receive (
    input  logic         clk,
    input  logic         reset,
    pcs_receive_if.slave pcs
);
    typedef enum logic [5:0] {
        LINK_FAILED = 6'b000001,
        WAIT_FOR_K  = 6'b000010,
        RX_K        = 6'b000100,
        IDLE_D      = 6'b001000,
        RECEIVE     = 6'b010000,
        EPD         = 6'b100000
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  rxd_q, rxd_d;
    logic        rx_dv_q, rx_dv_d;
    logic        rx_er_q, rx_er_d;
    logic        receiving_q, receiving_d;
    logic        frame_done_q, frame_done_d;
    logic [11:0] frame_len_q, frame_len_d;
    logic [11:0] count_q, count_d;
    logic [11:0] count_inc;

    logic        is_data, is_comma, is_s, is_t, is_r;
    logic [7:0]  octet;

    // Both running-disparity forms of every accepted code-group decode identically.
    always_comb begin
        is_data  = 1'b0;
        is_comma = 1'b0;
        is_s     = 1'b0;
        is_t     = 1'b0;
        is_r     = 1'b0;
        octet    = 8'h00;
        case (pcs.sudi)
            10'b1001110100, 10'b0110001011: begin is_data = 1'b1; octet = 8'h00; end
            10'b0111010100, 10'b1000101011: begin is_data = 1'b1; octet = 8'h01; end
            10'b1011010100, 10'b0100101011: begin is_data = 1'b1; octet = 8'h02; end
            10'b1100011011, 10'b1100010100: begin is_data = 1'b1; octet = 8'h03; end
            10'b1101010100, 10'b0010101011: begin is_data = 1'b1; octet = 8'h04; end
            10'b1010011011, 10'b1010010100: begin is_data = 1'b1; octet = 8'h05; end
            10'b0110011011, 10'b0110010100: begin is_data = 1'b1; octet = 8'h06; end
            10'b1110001011, 10'b0001110100: begin is_data = 1'b1; octet = 8'h07; end
            10'b1110010100, 10'b0001101011: begin is_data = 1'b1; octet = 8'h08; end
            10'b1001011011, 10'b1001010100: begin is_data = 1'b1; octet = 8'h09; end
            10'b1010010110:                 begin is_data = 1'b1; octet = 8'hC5; end
            10'b0110110101, 10'b1001000101: begin is_data = 1'b1; octet = 8'h50; end
            10'b0011111010, 10'b1100000101: is_comma = 1'b1;
            10'b1101101000, 10'b0010010111: is_s     = 1'b1;
            10'b1011101000, 10'b0100010111: is_t     = 1'b1;
            10'b1110101000, 10'b0001010111: is_r     = 1'b1;
            default: ;
        endcase
    end

    assign count_inc = (count_q == 12'hFFF) ? count_q : count_q + 12'd1;

    always_comb begin
        state_d      = state_q;
        rxd_d        = 8'h00;
        rx_dv_d      = 1'b0;
        rx_er_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        count_d      = count_q;
        if (!pcs.sync_status) begin
            // Losing sync inside a frame is flagged to GMII as one errored octet.
            state_d = LINK_FAILED;
            if (state_q == RECEIVE) begin
                rx_dv_d = 1'b1;
                rx_er_d = 1'b1;
            end
        end else begin
            case (state_q)
                LINK_FAILED: state_d = WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (is_comma && pcs.rx_even)
                        state_d = RX_K;
                end
                RX_K: begin
                    if (is_data && (octet == 8'hC5 || octet == 8'h50))
                        state_d = IDLE_D;
                    else
                        state_d = WAIT_FOR_K;
                end
                IDLE_D: begin
                    if (is_comma) begin
                        state_d = RX_K;
                    end else if (is_s) begin
                        state_d = RECEIVE;
                        rxd_d   = 8'h55;
                        rx_dv_d = 1'b1;
                        count_d = 12'd1;
                    end else begin
                        state_d = WAIT_FOR_K;
                    end
                end
                RECEIVE: begin
                    if (is_data) begin
                        rxd_d   = octet;
                        rx_dv_d = 1'b1;
                        count_d = count_inc;
                    end else if (is_comma) begin
                        state_d      = RX_K;
                        rx_dv_d      = 1'b1;
                        rx_er_d      = 1'b1;
                        frame_done_d = 1'b1;
                        frame_len_d  = count_q;
                    end else if (is_t) begin
                        state_d = EPD;
                    end else begin
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b1;
                        count_d = count_inc;
                    end
                end
                EPD: begin
                    state_d      = WAIT_FOR_K;
                    rx_er_d      = !is_r;
                    frame_done_d = 1'b1;
                    frame_len_d  = count_q;
                end
                default: state_d = LINK_FAILED;
            endcase
        end
        // The frame stays in progress until the end-of-packet delimiter is resolved.
        receiving_d = (state_d == RECEIVE) || (state_d == EPD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LINK_FAILED;
            rxd_q        <= 8'h00;
            rx_dv_q      <= 1'b0;
            rx_er_q      <= 1'b0;
            receiving_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= 12'h000;
            count_q      <= 12'h000;
        end else begin
            state_q      <= state_d;
            rxd_q        <= rxd_d;
            rx_dv_q      <= rx_dv_d;
            rx_er_q      <= rx_er_d;
            receiving_q  <= receiving_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            count_q      <= count_d;
        end
    end

    assign pcs.rxd        = rxd_q;
    assign pcs.rx_dv      = rx_dv_q;
    assign pcs.rx_er      = rx_er_q;
    assign pcs.receiving  = receiving_q;
    assign pcs.frame_done = frame_done_q;
    assign pcs.frame_len  = frame_len_q;
endmodule

// File: tb/tb_pcs_receive.sv
// Randomized bench for pcs_receive: a token-level receive model predicts every
// output cycle, plus directed frames for the delimiter, error and reset corners.
module tb_pcs_receive;
    logic clk;
    logic rst_n;
    pcs_receive_if pcs ();

    pcs_receive dut (
        .clk   (clk),
        .reset (rst_n),
        .pcs   (pcs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [9:0] K28P = 10'b0011111010, K28N = 10'b1100000101;
    localparam logic [9:0] SP   = 10'b1101101000, SN   = 10'b0010010111;
    localparam logic [9:0] TP   = 10'b1011101000, TN   = 10'b0100010111;
    localparam logic [9:0] RP   = 10'b1110101000, RN   = 10'b0001010111;
    localparam logic [9:0] BAD  = 10'b1111111111;

    // Dn.0 in both disparities (index 2n, 2n+1), then D5.6, then D16.2 pair.
    logic [9:0] dcode [24] = '{
        10'b1001110100, 10'b0110001011, 10'b0111010100, 10'b1000101011,
        10'b1011010100, 10'b0100101011, 10'b1100011011, 10'b1100010100,
        10'b1101010100, 10'b0010101011, 10'b1010011011, 10'b1010010100,
        10'b0110011011, 10'b0110010100, 10'b1110001011, 10'b0001110100,
        10'b1110010100, 10'b0001101011, 10'b1001011011, 10'b1001010100,
        10'b1010010110, 10'b1010010110, 10'b0110110101, 10'b1001000101
    };

    localparam int K_BAD = 0, K_DATA = 1, K_COMMA = 2, K_S = 3, K_T = 4, K_R = 5;
    localparam int M_DOWN = 0, M_HUNT = 1, M_GOTK = 2, M_IDLE = 3, M_FRAME = 4, M_TAIL = 5;

    int          m_st;
    int          m_cnt;
    int          m_flen;
    logic        m_recv;
    logic [31:0] exp_vec;

    byte unsigned seen_octets [$];
    int           last_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] observed();
        return {8'h00, pcs.rxd, pcs.rx_dv, pcs.rx_er, pcs.receiving, pcs.frame_done, pcs.frame_len};
    endfunction

    function automatic void classify(input logic [9:0] c, output int kind, output logic [7:0] oct);
        kind = K_BAD;
        oct  = 8'h00;
        for (int i = 0; i < 24; i++) begin
            if (dcode[i] == c) begin
                kind = K_DATA;
                oct  = (i < 20) ? 8'(i / 2) : ((i < 22) ? 8'hC5 : 8'h50);
            end
        end
        if (c == K28P || c == K28N) kind = K_COMMA;
        if (c == SP || c == SN)     kind = K_S;
        if (c == TP || c == TN)     kind = K_T;
        if (c == RP || c == RN)     kind = K_R;
    endfunction

    function automatic logic [9:0] enc(input int n);
        return dcode[2 * n + int'($urandom_range(0, 1))];
    endfunction

    function automatic logic [9:0] pick2(input logic [9:0] a, input logic [9:0] b);
        return ($urandom_range(0, 1) == 0) ? a : b;
    endfunction

    function automatic void model_reset();
        m_st   = M_DOWN;
        m_cnt  = 0;
        m_flen = 0;
        m_recv = 1'b0;
    endfunction

    // Predicts the output seen one clock after this code-group is presented.
    function automatic void model_step(input logic sync, input logic even, input logic [9:0] code);
        int         kind;
        logic [7:0] oct;
        logic [7:0] e_rxd = 8'h00;
        logic       e_dv = 1'b0, e_er = 1'b0, e_done = 1'b0;
        classify(code, kind, oct);
        if (!sync) begin
            if (m_st == M_FRAME) begin e_dv = 1'b1; e_er = 1'b1; end
            m_st   = M_DOWN;
            m_recv = 1'b0;
        end else begin
            case (m_st)
                M_DOWN: m_st = M_HUNT;
                M_HUNT: if (kind == K_COMMA && even) m_st = M_GOTK;
                M_GOTK: m_st = (kind == K_DATA && (oct == 8'hC5 || oct == 8'h50)) ? M_IDLE : M_HUNT;
                M_IDLE: begin
                    if (kind == K_COMMA) m_st = M_GOTK;
                    else if (kind == K_S) begin
                        m_st = M_FRAME; e_rxd = 8'h55; e_dv = 1'b1; m_cnt = 1; m_recv = 1'b1;
                    end else m_st = M_HUNT;
                end
                M_FRAME: begin
                    if (kind == K_DATA) begin
                        e_dv = 1'b1; e_rxd = oct; m_cnt = (m_cnt + 1 > 4095) ? 4095 : m_cnt + 1;
                    end else if (kind == K_COMMA) begin
                        e_dv = 1'b1; e_er = 1'b1; e_done = 1'b1; m_flen = m_cnt;
                        m_recv = 1'b0; m_st = M_GOTK;
                    end else if (kind == K_T) begin
                        m_st = M_TAIL;
                    end else begin
                        e_dv = 1'b1; e_er = 1'b1; m_cnt = (m_cnt + 1 > 4095) ? 4095 : m_cnt + 1;
                    end
                end
                default: begin
                    e_er = (kind != K_R); e_done = 1'b1; m_flen = m_cnt;
                    m_recv = 1'b0; m_st = M_HUNT;
                end
            endcase
        end
        exp_vec = {8'h00, e_rxd, e_dv, e_er, m_recv, e_done, 12'(m_flen)};
    endfunction

    task automatic step(input string tag, input logic sync, input logic even, input logic [9:0] code);
        pcs.sync_status = sync;
        pcs.rx_even     = even;
        pcs.sudi        = code;
        model_step(sync, even, code);
        @(posedge clk);
        #1;
        check(tag, observed(), exp_vec);
        if (pcs.rx_dv && !pcs.rx_er) seen_octets.push_back(pcs.rxd);
        if (pcs.frame_done) begin
            last_len = int'(pcs.frame_len);
            $display("frame end: len=%0d rx_er=%0b t=%0t", pcs.frame_len, pcs.rx_er, $time);
        end
    endtask

    task automatic idle(input string tag);
        repeat (2) begin
            step(tag, 1'b1, 1'b1, pick2(K28P, K28N));
            step(tag, 1'b1, 1'b0, dcode[22 + int'($urandom_range(0, 1))]);
        end
    endtask

    initial begin
        logic [31:0] packed_octets;
        int          r;
        rst_n           = 1'b0;
        pcs.sync_status = 1'b0;
        pcs.rx_even     = 1'b0;
        pcs.sudi        = 10'h000;
        last_len        = -1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", observed(), 32'h0);
        rst_n = 1'b1;

        // Basic frame 01 02 03
        seen_octets.delete();
        idle("basic");
        step("basic", 1'b1, 1'b0, pick2(SP, SN));
        for (int i = 1; i <= 3; i++) step("basic", 1'b1, 1'b0, enc(i));
        step("basic", 1'b1, 1'b0, pick2(TP, TN));
        step("basic", 1'b1, 1'b0, pick2(RP, RN));
        check("basic_cnt", 32'(seen_octets.size()), 32'd4);
        packed_octets = 32'h0;
        for (int i = 0; i < seen_octets.size() && i < 4; i++)
            packed_octets = {packed_octets[23:0], seen_octets[i]};
        check("basic_data", packed_octets, 32'h55010203);
        check("basic_len", 32'(last_len), 32'd4);

        // Invalid code-group in place of the second octet
        idle("bad_code");
        step("bad_code", 1'b1, 1'b0, SP);
        step("bad_code", 1'b1, 1'b0, enc(1));
        step("bad_code", 1'b1, 1'b0, BAD);
        check("bad_code_out", {8'h0, pcs.rxd, pcs.rx_dv, pcs.rx_er}, {8'h0, 8'h00, 2'b11});
        step("bad_code", 1'b1, 1'b0, enc(3));
        step("bad_code", 1'b1, 1'b0, TP);
        step("bad_code", 1'b1, 1'b0, RN);
        check("bad_code_len", 32'(last_len), 32'd4);

        // Sync loss during the second octet
        idle("sync_drop");
        step("sync_drop", 1'b1, 1'b0, SN);
        step("sync_drop", 1'b1, 1'b0, enc(1));
        step("sync_drop", 1'b0, 1'b0, enc(2));
        step("sync_drop", 1'b0, 1'b0, enc(3));
        step("sync_drop", 1'b1, 1'b0, TP);

        // Bad end-of-packet extension
        idle("epd_err");
        step("epd_err", 1'b1, 1'b0, SP);
        step("epd_err", 1'b1, 1'b0, enc(1));
        step("epd_err", 1'b1, 1'b0, TN);
        step("epd_err", 1'b1, 1'b0, enc(0));

        // Comma on the odd position never starts alignment
        step("odd_comma", 1'b1, 1'b0, K28P);
        step("odd_comma", 1'b1, 1'b0, SP);
        step("odd_comma", 1'b1, 1'b0, enc(4));

        // Early end by comma
        idle("early_end");
        step("early_end", 1'b1, 1'b0, SP);
        step("early_end", 1'b1, 1'b0, enc(5));
        step("early_end", 1'b1, 1'b0, K28N);
        step("early_end", 1'b1, 1'b0, dcode[20]);

        // Long frame saturates the length
        idle("long");
        step("long", 1'b1, 1'b0, SP);
        for (int i = 0; i < 5000; i++) step("long", 1'b1, 1'b0, enc(int'($urandom_range(0, 9))));
        step("long", 1'b1, 1'b0, TP);
        step("long", 1'b1, 1'b0, RP);
        check("long_len", 32'(last_len), 32'hFFF);

        // Asynchronous reset mid-frame
        idle("mid_rst");
        step("mid_rst", 1'b1, 1'b0, SN);
        for (int i = 0; i < 5; i++) step("mid_rst", 1'b1, 1'b0, enc(i));
        #2 rst_n = 1'b0;
        #1 check("async_rst", observed(), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random frames, with junk, errors, sync loss and all ending styles
        for (int f = 0; f < 120; f++) begin
            repeat ($urandom_range(1, 3)) begin
                step("rand", 1'b1, ($urandom_range(0, 9) != 0), pick2(K28P, K28N));
                step("rand", 1'b1, 1'b0, dcode[20 + int'($urandom_range(0, 3))]);
            end
            if ($urandom_range(0, 4) == 0) step("rand", 1'b1, 1'b1, 10'($urandom));
            step("rand", 1'b1, 1'b0, pick2(SP, SN));
            repeat ($urandom_range(1, 30)) begin
                r = int'($urandom_range(0, 99));
                if (r < 2)       step("rand", 1'b0, 1'b0, enc(0));
                else if (r < 5)  step("rand", 1'b1, 1'b0, BAD);
                else if (r < 7)  step("rand", 1'b1, 1'b0, pick2(RP, SN));
                else if (r < 10) step("rand", 1'b1, 1'b0, 10'($urandom));
                else             step("rand", 1'b1, 1'b0, dcode[$urandom_range(0, 23)]);
            end
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                step("rand", 1'b1, 1'b0, pick2(TP, TN));
                step("rand", 1'b1, 1'b0, pick2(RP, RN));
            end else if (r < 85) begin
                step("rand", 1'b1, 1'b0, pick2(TP, TN));
                step("rand", 1'b1, 1'b0, 10'($urandom));
            end else if (r < 95) begin
                step("rand", 1'b1, 1'b0, pick2(K28P, K28N));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
